muldiv_seq: RTL and testbench

Iterative sequencer for the RV32M multiply/divide ops, which the single-cycle ALU does not execute. It sits beside the ALU in the EX stage and runs one operation at a time using a shared shift/add-subtract datapath over XLEN iterations. It holds the pipeline via busy until the result is returned through a valid/ready handshake.

---
 rtl/muldiv_seq.sv | 244 ++++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq
//
// Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU.
// It runs one operation at a time on a single shift/add-subtract datapath,
// doing XLEN iterations. The EX stage is stalled through busy until the result
// has been taken through the valid/ready response handshake.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   req_valid   request present
//   req_ready   request accepted when req_valid && req_ready at a rising edge
//   req_op      funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   req_rs1     operand a (multiplicand / dividend)
//   req_rs2     operand b (multiplier / divisor)
//   flush       abort the in-flight op and drop any pending response
//   resp_valid  result available
//   resp_ready  consumer takes the result
//   resp_data   result
//   busy        high whenever the unit is not idle (EX stall)
// ---------------------------------------------------------------------------
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [XLEN-1:0] req_rs1,
   input  logic [XLEN-1:0] req_rs2,
   input  logic            flush,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_data,
   output logic            busy
);

   localparam int CW = $clog2(XLEN) + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN);
   localparam logic [CW-1:0]   CNT_LAST = CW'(1);
   localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

   // -----------------------------------------------------------------------
   // State
   // -----------------------------------------------------------------------
   logic [1:0]        state_reg, state_next;
   logic [CW-1:0]     cnt_reg;
   logic [2:0]        op_reg;
   // Multiplicand for multiplies, divisor for divides: the only operand the
   // adder needs besides the shifting product/remainder register.
   logic [XLEN-1:0]   opnd_reg;
   // {high, low}: multiply = {partial sum, multiplier};
   //              divide   = {partial remainder, dividend -> quotient}
   logic [2*XLEN-1:0] prod_reg;
   logic              neg_res_reg;   // product / quotient must be negated
   logic              neg_rem_reg;   // remainder takes the dividend's sign
   logic              resp_valid_reg;
   logic [XLEN-1:0]   resp_data_reg;
   logic              busy_reg;

   assign req_ready  = (state_reg == ST_IDLE) && !flush;
   assign resp_valid = resp_valid_reg;
   assign resp_data  = resp_data_reg;
   assign busy       = busy_reg;

   logic accept;
   assign accept = req_valid && req_ready;

   // -----------------------------------------------------------------------
   // Request decode: operand magnitudes, signs and the fast-path cases
   // -----------------------------------------------------------------------
   logic            a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, div_ovf, fast_path;
   logic [XLEN-1:0] special_data;

   assign a_signed = !((req_op == OP_MULHU) || (req_op == OP_DIVU) || (req_op == OP_REMU));
   assign b_signed = (req_op == OP_MUL) || (req_op == OP_MULH) ||
                     (req_op == OP_DIV) || (req_op == OP_REM);
   assign a_neg    = a_signed && req_rs1[XLEN-1];
   assign b_neg    = b_signed && req_rs2[XLEN-1];
   assign a_mag    = a_neg ? -req_rs1 : req_rs1;
   assign b_mag    = b_neg ? -req_rs2 : req_rs2;

   assign div_zero  = req_op[2] && (req_rs2 == '0);
   assign div_ovf   = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
                      (req_rs1 == SMIN) && (req_rs2 == '1);
   assign fast_path = div_zero || div_ovf;

   // req_op[1] separates remainder ops (11x) from quotient ops (10x).
   always_comb begin
      if (req_op[1])
         special_data = div_zero ? req_rs1 : '0;
      else
         special_data = div_zero ? '1 : SMIN;
   end

   // -----------------------------------------------------------------------
   // Shared iteration datapath. One XLEN+1 adder does either
   //   multiply: high + (lsb ? multiplicand : 0), then shift right
   //   divide  : (remainder << 1 | next dividend bit) - divisor
   // -----------------------------------------------------------------------
   logic              is_div;
   logic [XLEN:0]     add_a, add_b, add_sum;
   logic              q_bit;
   logic [2*XLEN-1:0] prod_iter;

   assign is_div = op_reg[2];

   always_comb begin
      if (is_div) begin
         add_a = prod_reg[2*XLEN-1:XLEN-1];
         add_b = ~{1'b0, opnd_reg};
      end else begin
         add_a = {1'b0, prod_reg[2*XLEN-1:XLEN]};
         add_b = prod_reg[0] ? {1'b0, opnd_reg} : '0;
      end
   end

   assign add_sum = add_a + add_b + {{XLEN{1'b0}}, is_div};

   // The shifted partial remainder never exceeds 2*divisor-1, so the top bit
   // of the difference is a reliable borrow flag.
   assign q_bit = !add_sum[XLEN];

   always_comb begin
      if (is_div)
         prod_iter = {(q_bit ? add_sum[XLEN-1:0] : add_a[XLEN-1:0]),
                      prod_reg[XLEN-2:0], q_bit};
      else
         prod_iter = {add_sum, prod_reg[XLEN-1:1]};
   end

   // -----------------------------------------------------------------------
   // Sign correction and result select, applied to the final iteration's
   // output so the result lands in resp_data on the last CALC edge.
   // -----------------------------------------------------------------------
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, result_sel;

   assign prod_fix = neg_res_reg ? -prod_iter : prod_iter;
   assign quot_fix = neg_res_reg ? -prod_iter[XLEN-1:0] : prod_iter[XLEN-1:0];
   assign rem_fix  = neg_rem_reg ? -prod_iter[2*XLEN-1:XLEN] : prod_iter[2*XLEN-1:XLEN];

   always_comb begin
      case (op_reg)
         OP_MUL:                       result_sel = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: result_sel = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              result_sel = quot_fix;
         OP_REM, OP_REMU:              result_sel = rem_fix;
         default:                      result_sel = '0;
      endcase
   end

   // -----------------------------------------------------------------------
   // Next-state logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (accept) state_next = fast_path ? ST_DONE : ST_CALC;
         ST_CALC: if (cnt_reg == CNT_LAST) state_next = ST_DONE;
         ST_DONE: if (resp_ready) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
      if (flush)
         state_next = ST_IDLE;
   end

   // -----------------------------------------------------------------------
   // Registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= '0;
         op_reg         <= '0;
         opnd_reg       <= '0;
         prod_reg       <= '0;
         neg_res_reg    <= 1'b0;
         neg_rem_reg    <= 1'b0;
         resp_valid_reg <= 1'b0;
         resp_data_reg  <= '0;
         busy_reg       <= 1'b0;
      end else begin
         state_reg <= state_next;
         busy_reg  <= (state_next != ST_IDLE);

         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  op_reg      <= req_op;
                  opnd_reg    <= req_op[2] ? b_mag : a_mag;
                  prod_reg    <= {{XLEN{1'b0}}, (req_op[2] ? a_mag : b_mag)};
                  neg_res_reg <= a_neg ^ b_neg;
                  neg_rem_reg <= a_neg;
                  if (fast_path) begin
                     cnt_reg        <= '0;
                     resp_data_reg  <= special_data;
                     resp_valid_reg <= 1'b1;
                  end else begin
                     cnt_reg <= CNT_LOAD;
                  end
               end
            end
            ST_CALC: begin
               prod_reg <= prod_iter;
               cnt_reg  <= cnt_reg - CNT_LAST;
               if ((cnt_reg == CNT_LAST) && !flush) begin
                  resp_data_reg  <= result_sel;
                  resp_valid_reg <= 1'b1;
               end
            end
            ST_DONE: begin
               if (resp_ready)
                  resp_valid_reg <= 1'b0;
            end
            default: ;
         endcase

         if (flush) begin
            cnt_reg        <= '0;
            resp_valid_reg <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq
//
// Self-checking bench for muldiv_seq (XLEN = 32). Expected results come from
// a plain-arithmetic RV32M model; a compare process checks resp_data on every
// cycle resp_valid is high and flags any response nobody is waiting for.
// Directed cases pin the model to hand-computed values, then randomized ops
// (biased toward corner operands) run against the model.
// ---------------------------------------------------------------------------
module tb_muldiv_seq;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;
   logic        flush;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        busy;

   int          total = 0;
   int          bad   = 0;
   bit          exp_pending = 0;
   logic [31:0] exp_data = '0;

   muldiv_seq #(.XLEN(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_rs1    (req_rs1),
      .req_rs2    (req_rs2),
      .flush      (flush),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "simulation timeout");
   end

   // Reference model: RV32M semantics with 64-bit arithmetic.
   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa, sb, ua, ub, q;
      logic [63:0] p;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      r  = '0;
      case (op)
         3'd0: begin p = 64'(sa * sb); r = p[31:0];  end
         3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
         3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
         3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
         3'd4: begin
            if (b == 32'd0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else begin q = sa / sb; r = q[31:0]; end
         end
         3'd5: begin
            if (b == 32'd0) r = 32'hFFFF_FFFF;
            else begin q = ua / ub; r = q[31:0]; end
         end
         3'd6: begin
            if (b == 32'd0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
            else begin q = sa % sb; r = q[31:0]; end
         end
         default: begin
            if (b == 32'd0) r = a;
            else begin q = ua % ub; r = q[31:0]; end
         end
      endcase
      return r;
   endfunction

   function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
      return (op[2] && b == 32'd0) ||
             ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 9))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Compare process: whenever a response is presented it must be the one
   // expected, and the unit must still be stalling the pipe.
   always @(negedge clk) begin
      if (!rst) begin
         total++;
         if (resp_valid && !exp_pending) begin
            bad++;
            $display("FAIL spurious_resp: got resp_valid=1 data=%h want resp_valid=0", resp_data);
         end else if (resp_valid && resp_data !== exp_data) begin
            bad++;
            $display("FAIL resp_data: got %h want %h", resp_data, exp_data);
         end
         if (resp_valid) begin
            total++;
            if (busy !== 1'b1) begin
               bad++;
               $display("FAIL busy_done: got %b want 1", busy);
            end
         end
      end
   end

   // Present a request until accepted; operands are scrambled right after
   // the accept edge since they must no longer matter.
   task automatic accept_op(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
      int k;
      k = 0;
      @(negedge clk);
      while (!req_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_rs1   = a;
      req_rs2   = b;
      @(posedge clk);
      #1;
      exp_pending = 1'b1;
      exp_data    = exp;
      req_valid   = 1'b0;
      req_op      = 3'($urandom);
      req_rs1     = $urandom;
      req_rs2     = $urandom;
   endtask

   // Wait for the response, measure latency in edges after the accept edge,
   // apply `hold` cycles of backpressure, then do a one-cycle handshake.
   task automatic finish_op(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int hold);
      int k;
      bit fast;
      fast = is_fast(op, a, b);
      k = 0;
      @(negedge clk);
      while (!resp_valid && k < 100) begin
         check("busy_calc", 32'(busy), 32'd1);
         @(negedge clk);
         k++;
      end
      check("latency", 32'(k), fast ? 32'd0 : 32'd32);
      repeat (hold) begin
         @(negedge clk);
         check("hold_valid", 32'(resp_valid), 32'd1);
      end
      #1 resp_ready = 1'b1;
      @(posedge clk);
      #1;
      exp_pending = 1'b0;
      resp_ready  = 1'b0;
      @(negedge clk);
      check("valid_drop", 32'(resp_valid), 32'd0);
      check("busy_drop", 32'(busy), 32'd0);
      check("ready_back", 32'(req_ready), 32'd1);
      $display("op=%0d a=%h b=%h exp=%h got=%h lat=%0d hold=%0d",
               op, a, b, exp_data, resp_data, k, hold);
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
      accept_op(op, a, b, model(op, a, b));
      finish_op(op, a, b, hold);
   endtask

   task automatic lit(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] want, input int hold);
      check("model_pin", model(op, a, b), want);
      accept_op(op, a, b, want);
      finish_op(op, a, b, hold);
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_op     = '0;
      req_rs1    = '0;
      req_rs2    = '0;
      flush      = 1'b0;
      resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_resp_data", resp_data, 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      rst = 1'b0;

      // Multiply, incl. high halves
      lit(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
      lit(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1);
      lit(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
      lit(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      // Divide / remainder (REMU with 5 cycles of backpressure)
      lit(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
      lit(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
      lit(3'd5, 32'd100, 32'd7, 32'd14, 0);
      lit(3'd7, 32'd100, 32'd7, 32'd2, 5);
      lit(3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 0);
      // Fast path
      lit(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
      lit(3'd6, 32'd5, 32'd0, 32'd5, 2);
      lit(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
      lit(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

      // Flush in IDLE blocks acceptance
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd0; req_rs1 = 32'd3; req_rs2 = 32'd4; flush = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("flush_idle_busy", 32'(busy), 32'd0);
      $display("flush in IDLE: busy=%b", busy);

      // Flush on the 10th CALC cycle: no response ever appears
      accept_op(3'd0, 32'd1234, 32'd5678, 32'd0);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1; exp_pending = 1'b0;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("flush_req_ready", 32'(req_ready), 32'd1);
      check("flush_resp_valid", 32'(resp_valid), 32'd0);
      check("flush_busy", 32'(busy), 32'd0);
      repeat (40) @(negedge clk);
      $display("flush mid-CALC: req_ready=%b", req_ready);
      lit(3'd5, 32'd9, 32'd3, 32'd3, 0);

      // Async reset mid-CALC, checked before the next rising edge
      accept_op(3'd0, 32'd3, 32'd5, 32'd15);
      repeat (5) @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b1; exp_pending = 1'b0;
      #1;
      check("arst_calc_valid", 32'(resp_valid), 32'd0);
      check("arst_calc_busy", 32'(busy), 32'd0);
      check("arst_calc_data", resp_data, 32'd0);
      #1 rst = 1'b0;
      $display("async reset mid-CALC: busy=%b data=%h", busy, resp_data);

      // Async reset mid-DONE
      accept_op(3'd7, 32'd100, 32'd7, 32'd2);
      repeat (40) @(negedge clk);
      check("done_valid_before_rst", 32'(resp_valid), 32'd1);
      #1 rst = 1'b1; exp_pending = 1'b0;
      #1;
      check("arst_done_valid", 32'(resp_valid), 32'd0);
      check("arst_done_busy", 32'(busy), 32'd0);
      check("arst_done_data", resp_data, 32'd0);
      #1 rst = 1'b0;
      $display("async reset mid-DONE: valid=%b data=%h", resp_valid, resp_data);

      // Flush in DONE with resp_ready high discards the result
      accept_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
      @(negedge clk);
      check("fast_valid", 32'(resp_valid), 32'd1);
      #1 flush = 1'b1; resp_ready = 1'b1; exp_pending = 1'b0;
      @(posedge clk);
      #1 flush = 1'b0; resp_ready = 1'b0;
      @(negedge clk);
      check("flush_done_valid", 32'(resp_valid), 32'd0);
      check("flush_done_busy", 32'(busy), 32'd0);
      $display("flush in DONE: valid=%b", resp_valid);

      // Randomized ops against the model
      for (int i = 0; i < 60; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         op = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         run_op(op, a, b, $urandom_range(0, 2));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
